// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the cache writeback path.
// Widths are derived from the block/word/address parameters of the instantiating module.
package cache_pkg;

  localparam int unsigned DefAddressWidth = 32;
  localparam int unsigned DefDataWidth    = 32;
  localparam int unsigned DefBlockSize    = 32;
  localparam int unsigned DefTagWidth     = DefAddressWidth - $clog2(DefBlockSize);

  function automatic int unsigned offsetWidth(input int unsigned blockSize);
    return $clog2(blockSize);
  endfunction

  function automatic int unsigned tagWidth(input int unsigned addressWidth,
                                           input int unsigned blockSize);
    return addressWidth - $clog2(blockSize);
  endfunction

  function automatic int unsigned wordsPerBlock(input int unsigned blockSize,
                                                input int unsigned dataWidth);
    return blockSize * 8 / dataWidth;
  endfunction

  // A single-word block still needs a one-bit beat counter.
  function automatic int unsigned beatWidth(input int unsigned blockSize,
                                            input int unsigned dataWidth);
    int unsigned wpb;
    wpb = blockSize * 8 / dataWidth;
    return (wpb > 1) ? $clog2(wpb) : 1;
  endfunction

  // Entry layout at the default geometry.
  typedef struct packed {
    logic [DefTagWidth-1:0]    tag;
    logic [DefBlockSize*8-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    SEND,
    WAIT_RESP
  } drain_state_e;

endpackage

// File: rtl/writeback_fifo.sv
// Victim-block storage for the writeback buffer: circular queue of {tag, data} entries
// with per-entry valid bits and a combinational tag snoop.
module writeback_fifo #(
  parameter int unsigned TAG_WIDTH = 27,
  parameter int unsigned DATA_BITS = 256,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       pushValid,
  output logic                       pushReady,
  input  logic [TAG_WIDTH-1:0]       pushTag,
  input  logic [DATA_BITS-1:0]       pushData,
  input  logic                       pop,
  output logic [TAG_WIDTH-1:0]       headTag,
  output logic [DATA_BITS-1:0]       headData,
  input  logic [TAG_WIDTH-1:0]       snoopTag,
  output logic                       snoopHit,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrWidth   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CountWidth = $clog2(DEPTH + 1);

  logic [TAG_WIDTH-1:0]  tagQ  [DEPTH];
  logic [DATA_BITS-1:0]  dataQ [DEPTH];
  logic [DEPTH-1:0]      validQ;
  logic [PtrWidth-1:0]   wrPtrQ, rdPtrQ, wrPtrNext, rdPtrNext;
  logic [CountWidth-1:0] countQ;
  logic                  push;

  assign pushReady = (countQ < CountWidth'(DEPTH));
  assign push      = pushValid && pushReady;

  assign wrPtrNext = (wrPtrQ == PtrWidth'(DEPTH - 1)) ? '0 : wrPtrQ + 1'b1;
  assign rdPtrNext = (rdPtrQ == PtrWidth'(DEPTH - 1)) ? '0 : rdPtrQ + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      validQ <= '0;
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (pop) begin
        validQ[rdPtrQ] <= 1'b0;
        rdPtrQ         <= rdPtrNext;
      end
      if (push) begin
        validQ[wrPtrQ] <= 1'b1;
        wrPtrQ         <= wrPtrNext;
      end
      case ({push, pop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

  // Payload storage needs no reset; validQ alone says what is held.
  always_ff @(posedge clk) begin
    if (push) begin
      tagQ[wrPtrQ]  <= pushTag;
      dataQ[wrPtrQ] <= pushData;
    end
  end

  assign headTag  = tagQ[rdPtrQ];
  assign headData = dataQ[rdPtrQ];
  assign count    = countQ;

  // A block being accepted this cycle must already stall a matching miss.
  always_comb begin
    snoopHit = push && (pushTag == snoopTag);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (validQ[i] && (tagQ[i] == snoopTag)) begin
        snoopHit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer: queues evicted dirty blocks and drains each one to memory a word per beat,
// waiting for the write response before popping it.
module writeback_buffer
  import cache_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BLOCK_SIZE    = 32,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [ADDRESS_WIDTH-1:0]   wb_addr,
  input  logic [BLOCK_SIZE*8-1:0]    wb_data,
  output logic                       wb_done,
  input  logic [ADDRESS_WIDTH-1:0]   snoop_addr,
  output logic                       snoop_hit,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDRESS_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic                       mem_resp,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned OffsetWidth = offsetWidth(BLOCK_SIZE);
  localparam int unsigned TagWidth    = tagWidth(ADDRESS_WIDTH, BLOCK_SIZE);
  localparam int unsigned Wpb         = wordsPerBlock(BLOCK_SIZE, DATA_WIDTH);
  localparam int unsigned BeatW       = beatWidth(BLOCK_SIZE, DATA_WIDTH);
  localparam int unsigned BlockBits   = BLOCK_SIZE * 8;

  drain_state_e            stateQ, stateD;
  logic [BeatW-1:0]        beatQ, beatD;
  logic                    wbDoneQ, wbDoneD;
  logic                    pop;
  logic [TagWidth-1:0]     headTag;
  logic [BlockBits-1:0]    headData;
  logic [OffsetWidth-1:0]  beatOffset;
  logic                    unusedOffsetBits;

  assign unusedOffsetBits = ^{wb_addr[OffsetWidth-1:0], snoop_addr[OffsetWidth-1:0]};

  writeback_fifo #(
    .TAG_WIDTH (TagWidth),
    .DATA_BITS (BlockBits),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .pushValid (wb_valid),
    .pushReady (wb_ready),
    .pushTag   (wb_addr[ADDRESS_WIDTH-1:OffsetWidth]),
    .pushData  (wb_data),
    .pop       (pop),
    .headTag   (headTag),
    .headData  (headData),
    .snoopTag  (snoop_addr[ADDRESS_WIDTH-1:OffsetWidth]),
    .snoopHit  (snoop_hit),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ  <= DRAIN_IDLE;
      beatQ   <= '0;
      wbDoneQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      beatQ   <= beatD;
      wbDoneQ <= wbDoneD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    beatD   = beatQ;
    wbDoneD = 1'b0;
    pop     = 1'b0;
    case (stateQ)
      DRAIN_IDLE: begin
        if (count != '0) begin
          beatD  = '0;
          stateD = SEND;
        end
      end
      SEND: begin
        if (mem_ready) begin
          if (beatQ == BeatW'(Wpb - 1)) begin
            stateD = WAIT_RESP;
          end else begin
            beatD = beatQ + 1'b1;
          end
        end
      end
      WAIT_RESP: begin
        if (mem_resp) begin
          pop     = 1'b1;
          wbDoneD = 1'b1;
          stateD  = DRAIN_IDLE;
        end
      end
      default: stateD = DRAIN_IDLE;
    endcase
  end

  assign beatOffset = OffsetWidth'(beatQ) * OffsetWidth'(DATA_WIDTH / 8);

  // Address and data are driven only while a beat is offered so they read 0 otherwise.
  assign mem_valid = (stateQ == SEND);
  assign mem_addr  = mem_valid ? {headTag, beatOffset} : '0;
  assign mem_wdata = mem_valid ? headData[beatQ*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign wb_done   = wbDoneQ;
  assign empty     = (count == '0);

endmodule
